network_memory_responder: RTL and testbench

NETWORK_MEMORY_RESPONDER -- requirements
Module: network_memory_responder

---
 rtl/network_memory_responder_pkg.sv | 18 +
 rtl/network_memory_responder_request_fifo.sv | 47 ++++
 rtl/network_memory_responder.sv | 138 +++++++++++++
 tb/tb_network_memory_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_memory_responder_pkg.sv
// Message codes shared by the network responder and its request queue.
// Compile-time definitions only: no logic, no latency, no flow control.
// Every block that speaks the network/memory protocol imports these codes.
package network_memory_responder_pkg;

    localparam int MSG_CODE_BITS = 3;

    typedef enum logic [MSG_CODE_BITS-1:0] {
        NO_REQ    = 3'd0,
        R_REQ     = 3'd1,
        WB_REQ    = 3'd2,
        MEM_READY = 3'd3,
        MEM_SENT  = 3'd4,
        MEM_RESP  = 3'd5,
        NET_NACK  = 3'd6
    } msg_e;

endpackage

// File: rtl/network_memory_responder_request_fifo.sv
// Generic request queue; head word is visible combinationally while not empty.
// Latency: a push is visible at the head one cycle later.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module request_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB tells a full queue apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/network_memory_responder.sv
// Queues network read/writeback requests and forwards them one at a time to main memory.
// Latency: request to resp2mem two edges; memory response to resp2net one edge; NACK after TIMEOUT_CYCLES.
// Backpressure: none toward the network; requests arriving at a full queue are dropped and flag overflow.
module network_memory_responder
    import network_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MSG_BITS       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      net2resp_msg,
    input  logic [ADDRESS_WIDTH-1:0] net2resp_address,
    input  logic [DATA_WIDTH-1:0]    net2resp_data,
    output logic [MSG_BITS-1:0]      resp2net_msg,
    output logic [ADDRESS_WIDTH-1:0] resp2net_address,
    output logic [DATA_WIDTH-1:0]    resp2net_data,
    output logic [MSG_BITS-1:0]      resp2mem_msg,
    output logic [ADDRESS_WIDTH-1:0] resp2mem_address,
    output logic [DATA_WIDTH-1:0]    resp2mem_data,
    input  logic [MSG_BITS-1:0]      mem2resp_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem2resp_address,
    input  logic [DATA_WIDTH-1:0]    mem2resp_data,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     busy
);

    localparam int REQ_W = MSG_BITS + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_RESPOND  = 2'd2;

    // Shared codes resized to the configured message field width.
    localparam logic [MSG_BITS-1:0] C_NO_REQ    = MSG_BITS'(NO_REQ);
    localparam logic [MSG_BITS-1:0] C_R_REQ     = MSG_BITS'(R_REQ);
    localparam logic [MSG_BITS-1:0] C_WB_REQ    = MSG_BITS'(WB_REQ);
    localparam logic [MSG_BITS-1:0] C_MEM_READY = MSG_BITS'(MEM_READY);
    localparam logic [MSG_BITS-1:0] C_MEM_SENT  = MSG_BITS'(MEM_SENT);
    localparam logic [MSG_BITS-1:0] C_MEM_RESP  = MSG_BITS'(MEM_RESP);
    localparam logic [MSG_BITS-1:0] C_NET_NACK  = MSG_BITS'(NET_NACK);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [REQ_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             net_push;
    logic             fifo_pop;
    logic             rd_hit;
    logic             wb_hit;
    logic             timed_out;

    assign net_push  = (net2resp_msg == C_R_REQ) || (net2resp_msg == C_WB_REQ);
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
    assign busy      = (state != S_IDLE);

    // The outstanding request is the one still held on resp2mem.
    assign rd_hit    = (resp2mem_msg == C_R_REQ) && (mem2resp_msg == C_MEM_READY)
                       && (mem2resp_address == resp2mem_address);
    assign wb_hit    = (resp2mem_msg == C_WB_REQ) && (mem2resp_msg == C_MEM_SENT)
                       && (mem2resp_address == resp2mem_address);
    assign timed_out = (wait_cnt == CNT_LAST);

    request_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_request_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (net_push),
        .push_dat ({net2resp_msg, net2resp_address, net2resp_data}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= S_IDLE;
            wait_cnt         <= '0;
            overflow         <= 1'b0;
            resp2net_msg     <= C_NO_REQ;
            resp2net_address <= '0;
            resp2net_data    <= '0;
            resp2mem_msg     <= C_NO_REQ;
            resp2mem_address <= '0;
            resp2mem_data    <= '0;
        end else begin
            if (net_push && fifo_full && !fifo_pop) overflow <= 1'b1;

            // resp2net is a single-cycle pulse; only a completing MEM_WAIT overrides this.
            resp2net_msg     <= C_NO_REQ;
            resp2net_address <= '0;
            resp2net_data    <= '0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        resp2mem_msg     <= fifo_head[REQ_W-1 -: MSG_BITS];
                        resp2mem_address <= fifo_head[DATA_WIDTH +: ADDRESS_WIDTH];
                        resp2mem_data    <= fifo_head[DATA_WIDTH-1:0];
                        wait_cnt         <= '0;
                        state            <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (rd_hit) begin
                        resp2net_msg  <= C_MEM_RESP;
                        resp2net_data <= mem2resp_data;
                    end else if (wb_hit) begin
                        resp2net_msg  <= C_MEM_SENT;
                        resp2net_data <= resp2mem_data;
                    end else if (timed_out) begin
                        resp2net_msg  <= C_NET_NACK;
                    end
                    if (rd_hit || wb_hit || timed_out) begin
                        resp2net_address <= resp2mem_address;
                        resp2mem_msg     <= C_NO_REQ;
                        resp2mem_address <= '0;
                        resp2mem_data    <= '0;
                        state            <= S_RESPOND;
                    end
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_network_memory_responder.sv
// Directed table plus randomized bursts against a queue-based model of the responder.
module tb_network_memory_responder;
    import network_memory_responder_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 3;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [MB-1:0] net2resp_msg = '0;
    logic [AW-1:0] net2resp_address = '0;
    logic [DW-1:0] net2resp_data = '0;
    logic [MB-1:0] resp2net_msg;
    logic [AW-1:0] resp2net_address;
    logic [DW-1:0] resp2net_data;
    logic [MB-1:0] resp2mem_msg;
    logic [AW-1:0] resp2mem_address;
    logic [DW-1:0] resp2mem_data;
    logic [MB-1:0] mem2resp_msg = '0;
    logic [AW-1:0] mem2resp_address = '0;
    logic [DW-1:0] mem2resp_data = '0;
    logic          fifo_full;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  msg;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;   // 0 = memory stays silent
        int          decoy;   // 1 = wrong address first, 2 = wrong message first
        logic [31:0] mdata;
        logic [2:0]  xmsg;
        logic [31:0] xdata;
    } vec_t;

    vec_t vec[9];
    vec_t pq[$];
    vec_t eq[$];

    network_memory_responder #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .MSG_BITS       (MB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .net2resp_msg     (net2resp_msg),
        .net2resp_address (net2resp_address),
        .net2resp_data    (net2resp_data),
        .resp2net_msg     (resp2net_msg),
        .resp2net_address (resp2net_address),
        .resp2net_data    (resp2net_data),
        .resp2mem_msg     (resp2mem_msg),
        .resp2mem_address (resp2mem_address),
        .resp2mem_data    (resp2mem_data),
        .mem2resp_msg     (mem2resp_msg),
        .mem2resp_address (mem2resp_address),
        .mem2resp_data    (mem2resp_data),
        .fifo_full        (fifo_full),
        .overflow         (overflow),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        net2resp_msg     = m;
        net2resp_address = a;
        net2resp_data    = d;
        tick();
        net2resp_msg     = NO_REQ;
        net2resp_address = '0;
        net2resp_data    = '0;
    endtask

    task automatic mem_idle();
        mem2resp_msg     = NO_REQ;
        mem2resp_address = '0;
        mem2resp_data    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/resp2net"}, 128'({resp2net_msg, resp2net_address, resp2net_data}), 128'(0));
        check({tag, "/resp2mem"}, 128'({resp2mem_msg, resp2mem_address, resp2mem_data}), 128'(0));
        check({tag, "/status"}, 128'({fifo_full, overflow, busy}), 128'(0));
    endtask

    // Expected network answer from the memory delay alone: a response sampled
    // within TO edges of the request reaching memory wins, otherwise NACK with data 0.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.delay < 1 || v.delay > TO) begin
            r.xmsg  = NET_NACK;
            r.xdata = '0;
        end else if (v.msg == R_REQ) begin
            r.xmsg  = MEM_RESP;
            r.xdata = v.mdata;
        end else begin
            r.xmsg  = MEM_SENT;
            r.xdata = v.data;
        end
        return r;
    endfunction

    // Acts as main memory for the next outstanding request and checks the answer.
    task automatic serve(input vec_t v, input string tag, output int waited);
        int   k;
        bit   hold_ok;
        logic [2:0] ok_msg;
        logic [2:0] bad_msg;
        ok_msg  = (v.msg == R_REQ) ? MEM_READY : MEM_SENT;
        bad_msg = (v.msg == R_REQ) ? MEM_SENT : MEM_READY;
        waited = 0;
        while (resp2mem_msg == NO_REQ && waited < 60) begin
            tick();
            waited++;
        end
        check({tag, "/mem_req"}, 128'({resp2mem_msg, resp2mem_address, resp2mem_data}),
              128'({v.msg, v.addr, v.data}));
        k = 0;
        hold_ok = 1'b1;
        while (resp2net_msg == NO_REQ && k < TO + 4) begin
            mem_idle();
            if (k + 1 == 1 && v.decoy == 1) begin
                mem2resp_msg = ok_msg; mem2resp_address = v.addr ^ 32'h4; mem2resp_data = 32'hDEAD_BEEF;
            end
            if (k + 1 == 1 && v.decoy == 2) begin
                mem2resp_msg = bad_msg; mem2resp_address = v.addr; mem2resp_data = 32'hFEED_0000;
            end
            if (k + 1 == v.delay) begin
                mem2resp_msg = ok_msg; mem2resp_address = v.addr; mem2resp_data = v.mdata;
            end
            tick();
            k++;
            if (resp2net_msg == NO_REQ &&
                {resp2mem_msg, resp2mem_address, resp2mem_data} != {v.msg, v.addr, v.data})
                hold_ok = 1'b0;
        end
        mem_idle();
        check({tag, "/mem_hold"}, 128'(hold_ok), 128'(1));
        check({tag, "/latency"}, 128'(k), 128'((v.delay >= 1 && v.delay <= TO) ? v.delay : TO));
        check({tag, "/resp"}, 128'({resp2net_msg, resp2net_address, resp2net_data}),
              128'({v.xmsg, v.addr, v.xdata}));
        check({tag, "/mem_gap"}, 128'(resp2mem_msg), 128'(NO_REQ));
        tick();
        check({tag, "/one_cycle"}, 128'({resp2net_msg, busy}), 128'({NO_REQ, 1'b0}));
    endtask

    initial begin
        int   w;
        bit   spurious;
        vec_t t;

        vec[0] = '{R_REQ,  32'h10, 32'h0,  3, 0, 32'hCAFE0001, MEM_RESP, 32'hCAFE0001};
        vec[1] = '{WB_REQ, 32'h20, 32'h55, 4, 0, 32'h0,        MEM_SENT, 32'h55};
        vec[2] = '{R_REQ,  32'h40, 32'h0,  3, 1, 32'h12345678, MEM_RESP, 32'h12345678};
        vec[3] = '{WB_REQ, 32'h30, 32'hA5, 2, 2, 32'h0,        MEM_SENT, 32'hA5};
        vec[4] = '{R_REQ,  32'h50, 32'h0,  2, 2, 32'h0BADF00D, MEM_RESP, 32'h0BADF00D};
        vec[5] = '{R_REQ,  32'h70, 32'h0,  TO, 0, 32'h7,       MEM_RESP, 32'h7};
        vec[6] = '{R_REQ,  32'h90, 32'h0,  0, 0, 32'h0,        NET_NACK, 32'h0};
        vec[7] = '{WB_REQ, 32'hA0, 32'h9,  TO + 1, 0, 32'h0,   NET_NACK, 32'h0};
        vec[8] = '{R_REQ,  32'h14, 32'h3,  1, 0, 32'h11111111, MEM_RESP, 32'h11111111};

        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Non-request codes on the network side must not be queued.
        send(MEM_READY, 32'h11, 32'h1);
        send(NET_NACK, 32'h12, 32'h2);
        send(3'd7, 32'h13, 32'h3);
        tick();
        tick();
        check("ignored_codes", 128'({busy, resp2mem_msg, fifo_full}), 128'({1'b0, NO_REQ, 1'b0}));

        for (int i = 0; i < 9; i++) begin
            send(vec[i].msg, vec[i].addr, vec[i].data);
            serve(vec[i], $sformatf("vec%0d", i), w);
            check($sformatf("vec%0d/issue_latency", i), 128'(w), 128'(1));
        end

        // Full/overflow: keep one request stalled while five more arrive.
        send(R_REQ, 32'h80, 32'h0);
        tick();
        check("blocker/mem_req", 128'({resp2mem_msg, resp2mem_address}), 128'({R_REQ, 32'h80}));
        for (int i = 0; i < 5; i++) begin
            send(R_REQ, 32'(i), 32'h0);
            if (i == 3) check("full_after_4", 128'({fifo_full, overflow}), 128'({1'b1, 1'b0}));
            if (i == 4) check("overflow_after_5", 128'({fifo_full, overflow}), 128'({1'b1, 1'b1}));
        end
        w = 5;
        while (resp2net_msg == NO_REQ && w < TO + 4) begin
            tick();
            w++;
        end
        check("blocker/nack_latency", 128'(w), 128'(TO));
        check("blocker/nack", 128'({resp2net_msg, resp2net_address, resp2net_data}),
              128'({NET_NACK, 32'h80, 32'h0}));
        for (int i = 0; i < 4; i++) begin
            t = model('{R_REQ, 32'(i), 32'h0, 2, 0, 32'h100 + 32'(i), NO_REQ, 32'h0});
            serve(t, $sformatf("queued%0d", i), w);
        end
        repeat (6) tick();
        check("dropped_never_served", 128'({busy, resp2mem_msg, fifo_full, overflow}),
              128'({1'b0, NO_REQ, 1'b0, 1'b1}));

        // Random bursts: network pushes and memory replies run concurrently.
        for (int b = 0; b < 12; b++) begin
            int nvalid;
            pq.delete();
            eq.delete();
            nvalid = $urandom_range(1, 5);
            while (nvalid > 0) begin
                vec_t p;
                int j;
                p.addr  = $urandom;
                p.data  = $urandom;
                p.mdata = $urandom;
                p.delay = $urandom_range(0, TO + 3);
                p.decoy = (p.delay >= 2) ? $urandom_range(0, 2) : 0;
                p.xmsg  = NO_REQ;
                p.xdata = '0;
                if ($urandom_range(0, 3) == 0) begin
                    j = $urandom_range(0, 5);
                    p.msg = (j == 0) ? 3'd0 : 3'(j + 2);
                end else begin
                    p.msg = ($urandom_range(0, 1) == 0) ? R_REQ : WB_REQ;
                end
                pq.push_back(p);
                if (p.msg == R_REQ || p.msg == WB_REQ) begin
                    eq.push_back(model(p));
                    nvalid--;
                end
            end
            fork
                begin
                    for (int i = 0; i < pq.size(); i++) send(pq[i].msg, pq[i].addr, pq[i].data);
                end
                begin
                    int ww;
                    for (int i = 0; i < eq.size(); i++) serve(eq[i], $sformatf("rnd%0d_%0d", b, i), ww);
                end
            join
        end
        repeat (4) tick();
        check("random/drained", 128'({busy, fifo_full}), 128'(0));

        // Reset in the middle of a memory wait abandons the request.
        send(R_REQ, 32'h60, 32'h0);
        tick();
        check("midreset/busy_before", 128'(busy), 128'(1));
        reset = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b1;
        mem2resp_msg = MEM_READY; mem2resp_address = 32'h60; mem2resp_data = 32'h66;
        tick();
        mem_idle();
        spurious = 1'b0;
        repeat (8) begin
            if (resp2net_msg != NO_REQ || busy) spurious = 1'b1;
            tick();
        end
        check("midreset/late_mem_ignored", 128'(spurious), 128'(0));

        t = model('{WB_REQ, 32'h64, 32'h77, 2, 0, 32'h0, NO_REQ, 32'h0});
        send(t.msg, t.addr, t.data);
        serve(t, "after_reset", w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
